issue_scoreboard: RTL



---
 rtl/sb_pkg.sv | 44 ++++
 rtl/issue_scoreboard_if.sv | 40 ++++
 rtl/sb_unit_fsm.sv | 41 ++++
 rtl/issue_scoreboard.sv | 105 ++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for issue_scoreboard: function-unit codes, opcodes, unit state,
// and the source-operand usage decoders.
package sb_pkg;

  localparam logic [2:0] FN_NONE   = 3'd0;
  localparam logic [2:0] FN_ALU    = 3'd1;
  localparam logic [2:0] FN_MULDIV = 3'd2;
  localparam logic [2:0] FN_MEM    = 3'd3;
  localparam logic [2:0] FN_CSR    = 3'd4;
  localparam logic [2:0] FN_BRANCH = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } unit_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode, input logic [2:0] funct3);
    logic used;
    used = 1'b1;
    if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL) begin
      used = 1'b0;
    end else if (opcode == OP_SYSTEM) begin
      // CSR immediate forms and ECALL/EBREAK/xRET carry no rs1 operand
      used = !(funct3[2] || funct3 == 3'd0);
    end
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_OP) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-side bundle of issue_scoreboard: decode instruction fields, write-back and
// unit-done returns, and the stall/issue/debug outputs.
interface issue_scoreboard_if #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
);

  logic             valid3;
  logic [6:0]       opcode3;
  logic [2:0]       funct3_3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd3;
  logic             we3;
  logic [2:0]       fn3;
  logic             flush;
  logic             wb0_valid;
  logic [4:0]       wb0_rd;
  logic             wb1_valid;
  logic [4:0]       wb1_rd;
  logic             md_done;
  logic             mem_done;
  logic             stall;
  logic             issue;
  logic [NREG-1:0]  pend_o;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output valid3, opcode3, funct3_3, rs1, rs2, rd3, we3, fn3, flush,
    output wb0_valid, wb0_rd, wb1_valid, wb1_rd, md_done, mem_done,
    input  stall, issue, pend_o, stall_cycles
  );

  modport slave (
    input  valid3, opcode3, funct3_3, rs1, rs2, rd3, we3, fn3, flush,
    input  wb0_valid, wb0_rd, wb1_valid, wb1_rd, md_done, mem_done,
    output stall, issue, pend_o, stall_cycles
  );

endinterface

// File: rtl/sb_unit_fsm.sv
// IDLE/BUSY occupancy tracker for one multi-cycle function unit.
module sb_unit_fsm
  import sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done,
  output logic busy
);

  unit_state_e r_state;
  unit_state_e w_state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        // A done while idle is stale and ignored
        if (start) w_state_next = BUSY;
      end
      BUSY: begin
        // A new start alongside done keeps the unit occupied back-to-back
        if (start)     w_state_next = BUSY;
        else if (done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state == BUSY);

endmodule

// File: rtl/issue_scoreboard.sv
// Register/unit scoreboard between decode and execute: RAW/WAW/structural hazard check,
// pending-write tracking and a saturating stall counter. Optional macro: SB_WB_BYPASS_EN.
module issue_scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  issue_scoreboard_if.slave sb
);

  logic [NREG-1:0]  r_pend;
  logic [NREG-1:0]  w_pend_next;
  logic [NREG-1:0]  w_pend_chk;
  logic [NREG-1:0]  w_clr;
  logic [NREG-1:0]  w_set;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_struct;
  logic w_hazard;
  logic w_stall;
  logic w_issue;
  logic w_md_busy;
  logic w_mem_busy;
  logic w_md_start;
  logic w_mem_start;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_clr[i] = (sb.wb0_valid && (sb.wb0_rd == 5'(i))) ||
                 (sb.wb1_valid && (sb.wb1_rd == 5'(i)));
    end
  end

`ifdef SB_WB_BYPASS_EN
  // Same-cycle write-back resolves the dependency; the regfile forwards the value
  assign w_pend_chk = r_pend & ~w_clr;
`else
  assign w_pend_chk = r_pend;
`endif

  always_comb begin
    w_raw1   = uses_rs1(sb.opcode3, sb.funct3_3) && (sb.rs1 != 5'd0) && w_pend_chk[sb.rs1];
    w_raw2   = uses_rs2(sb.opcode3) && (sb.rs2 != 5'd0) && w_pend_chk[sb.rs2];
    w_waw    = sb.we3 && (sb.rd3 != 5'd0) && w_pend_chk[sb.rd3];
    w_struct = ((sb.fn3 == FN_MULDIV) && w_md_busy) || ((sb.fn3 == FN_MEM) && w_mem_busy);
    w_hazard = w_raw1 || w_raw2 || w_waw || w_struct;
  end

  assign w_stall = !rst && sb.valid3 && w_hazard && !sb.flush;
  assign w_issue = !rst && sb.valid3 && !w_hazard && !sb.flush;

  always_comb begin
    w_set = '0;
    if (w_issue && sb.we3 && (sb.rd3 != 5'd0)) begin
      w_set[sb.rd3] = 1'b1;
    end
    // Set is ORed after the clear so an issue beats a same-register write-back
    w_pend_next    = (r_pend & ~w_clr) | w_set;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pend <= w_pend_next;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign w_md_start  = w_issue && (sb.fn3 == FN_MULDIV);
  assign w_mem_start = w_issue && (sb.fn3 == FN_MEM);

  sb_unit_fsm u_md_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (w_md_start),
    .done  (sb.md_done),
    .busy  (w_md_busy)
  );

  sb_unit_fsm u_mem_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (w_mem_start),
    .done  (sb.mem_done),
    .busy  (w_mem_busy)
  );

  assign sb.stall        = w_stall;
  assign sb.issue        = w_issue;
  assign sb.pend_o       = r_pend;
  assign sb.stall_cycles = r_stall_cnt;

endmodule
